// File: rtl/pdatapath_pkg.sv
// Shared encodings for the self-sequencing datapath: FSM states, ALU/shift/source
// codes, status bit positions and the latched command fields.
package pdatapath_pkg;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_e;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [1:0] SRC_C     = 2'b00;
  localparam logic [1:0] SRC_MDATA = 2'b01;
  localparam logic [1:0] SRC_IMM8  = 2'b10;
  localparam logic [1:0] SRC_PC    = 2'b11;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;

  // Width-independent part of a command; register indices are held separately.
  typedef struct packed {
    logic [1:0] src;
    logic [1:0] alu_op;
    logic [1:0] shift;
    logic       asel;
    logic       bsel;
    logic       wb_en;
    logic       loads;
  } ctl_t;

endpackage

// File: rtl/pregfile.sv
// DW x NREG register file: one write port, one read port, async active-high clear.
// Optional DBG_PORT_EN adds a side-effect-free combinational debug read port.
module pregfile #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] waddr,
  input  logic [DW-1:0]           wdata,
  input  logic [$clog2(NREG)-1:0] raddr,
  output logic [DW-1:0]           rdata
`ifdef DBG_PORT_EN
  ,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [DW-1:0]           dbg_data
`endif
);

  logic [NREG-1:0][DW-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

`ifdef DBG_PORT_EN
  assign dbg_data = mem_q[dbg_addr];
`endif

endmodule

// File: rtl/pdatapath_seq.sv
// Self-sequencing datapath: one start pulse runs read-A/read-B/exec/write-back
// (or a direct write-back for non-ALU sources). DBG_PORT_EN adds dbg_addr/dbg_data.
module pdatapath_seq #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              src,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [$clog2(NREG)-1:0] rn,
  input  logic [$clog2(NREG)-1:0] rm,
  input  logic [1:0]              ALUop,
  input  logic [1:0]              shift,
  input  logic                    asel,
  input  logic                    bsel,
  input  logic                    wb_en,
  input  logic                    loads,
  input  logic [DW-1:0]           mdata,
  input  logic [DW-1:0]           sximm8,
  input  logic [DW-1:0]           sximm5,
  input  logic [DW-1:0]           pc,
  output logic                    busy,
  output logic                    done,
  output logic [DW-1:0]           datapath_out,
  output logic [2:0]              Z_out
`ifdef DBG_PORT_EN
  ,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [DW-1:0]           dbg_data
`endif
);
  import pdatapath_pkg::*;

  localparam int AW = $clog2(NREG);

  state_e          state_q, state_d;
  ctl_t            ctl_q, ctl_d;
  logic [AW-1:0]   rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]      status_q, status_d;

  logic            rf_we;
  logic [AW-1:0]   rf_raddr;
  logic [DW-1:0]   rf_rdata, rf_wdata;

  logic [DW-1:0]   b_sh, ain, bin, alu_res, pc_ext, wb_data;
  logic [2:0]      alu_flags;
  logic            pc_unused;

  pregfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rd_q),
    .wdata   (rf_wdata),
    .raddr   (rf_raddr),
    .rdata   (rf_rdata)
`ifdef DBG_PORT_EN
    ,
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
`endif
  );

  // Shifter sits in front of the bsel mux, so immediates are never shifted.
  always_comb begin
    case (ctl_q.shift)
      SH_LSL:  b_sh = {b_q[DW-2:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, b_q[DW-1:1]};
      SH_ASR:  b_sh = {b_q[DW-1], b_q[DW-1:1]};
      default: b_sh = b_q;
    endcase
    ain = ctl_q.asel ? '0 : a_q;
    bin = ctl_q.bsel ? sximm5 : b_sh;
  end

  always_comb begin
    alu_res         = '0;
    alu_flags       = '0;
    case (ctl_q.alu_op)
      ALU_ADD: begin
        alu_res         = ain + bin;
        alu_flags[ST_V] = (ain[DW-1] == bin[DW-1]) && (alu_res[DW-1] != ain[DW-1]);
      end
      ALU_SUB: begin
        alu_res         = ain - bin;
        alu_flags[ST_V] = (ain[DW-1] != bin[DW-1]) && (alu_res[DW-1] != ain[DW-1]);
      end
      ALU_AND: alu_res = ain & bin;
      default: alu_res = ~bin;
    endcase
    alu_flags[ST_Z] = (alu_res == '0);
    alu_flags[ST_N] = alu_res[DW-1];
  end

  // pc contributes at most its low 9 bits; narrower words take what fits.
  always_comb begin
    pc_ext = '0;
    for (int i = 0; i < DW; i++) pc_ext[i] = (i < 9) ? pc[i] : 1'b0;
  end
  assign pc_unused = ^pc;

  always_comb begin
    case (ctl_q.src)
      SRC_MDATA: wb_data = mdata;
      SRC_IMM8:  wb_data = sximm8;
      SRC_PC:    wb_data = pc_ext;
      default:   wb_data = c_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ctl_d    = ctl_q;
    rd_d     = rd_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    status_d = status_q;
    rf_raddr = rn_q;
    rf_we    = 1'b0;
    rf_wdata = wb_data;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          ctl_d   = '{src: src, alu_op: ALUop, shift: shift, asel: asel,
                      bsel: bsel, wb_en: wb_en, loads: loads};
          rd_d    = rd;
          rn_d    = rn;
          rm_d    = rm;
          state_d = (src == SRC_C) ? RD_A : WB;
        end
      end
      RD_A: begin
        rf_raddr = rn_q;
        a_d      = rf_rdata;
        state_d  = RD_B;
      end
      RD_B: begin
        rf_raddr = rm_q;
        b_d      = rf_rdata;
        state_d  = EXEC;
      end
      EXEC: begin
        c_d = alu_res;
        if (ctl_q.loads) status_d = alu_flags;
        state_d = WB;
      end
      WB: begin
        done    = 1'b1;
        rf_we   = ctl_q.wb_en;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ctl_q    <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      rd_q     <= rd_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  assign datapath_out = c_q;
  assign Z_out        = status_q;

endmodule

// File: tb/tb_pdatapath_seq.sv
// Directed bench for pdatapath_seq: default 16x8 instance plus an 8-bit/4-register
// instance sharing the command bus, each with its own start.
module tb_pdatapath_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [1:0]  src = '0, alu_op = '0, shift = '0;
  logic [2:0]  rd = '0, rn = '0, rm = '0;
  logic        asel = 1'b0, bsel = 1'b0, wb_en = 1'b0, loads = 1'b0;
  logic [15:0] mdata = '0, sximm8 = '0, sximm5 = '0, pc = '0;

  logic        busy1, done1, busy2, done2;
  logic [15:0] dout1;
  logic [7:0]  dout2;
  logic [2:0]  z1, z2;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DBG_PORT_EN
  logic [2:0]  dbg_addr1 = '0;
  logic [1:0]  dbg_addr2 = '0;
  logic [15:0] dbg_data1;
  logic [7:0]  dbg_data2;
`endif

  always #5 clk = ~clk;

  pdatapath_seq #(.DW(16), .NREG(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .src(src), .rd(rd), .rn(rn), .rm(rm),
    .ALUop(alu_op), .shift(shift), .asel(asel), .bsel(bsel), .wb_en(wb_en),
    .loads(loads), .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5), .pc(pc),
    .busy(busy1), .done(done1), .datapath_out(dout1), .Z_out(z1)
`ifdef DBG_PORT_EN
    , .dbg_addr(dbg_addr1), .dbg_data(dbg_data1)
`endif
  );

  pdatapath_seq #(.DW(8), .NREG(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .src(src), .rd(rd[1:0]), .rn(rn[1:0]),
    .rm(rm[1:0]), .ALUop(alu_op), .shift(shift), .asel(asel), .bsel(bsel),
    .wb_en(wb_en), .loads(loads), .mdata(mdata[7:0]), .sximm8(sximm8[7:0]),
    .sximm5(sximm5[7:0]), .pc(pc[7:0]),
    .busy(busy2), .done(done2), .datapath_out(dout2), .Z_out(z2)
`ifdef DBG_PORT_EN
    , .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic done_u(input int u);
    return (u == 0) ? done1 : done2;
  endfunction

  // Issue one command and wait (bounded) for done; lat = cycles from start to done.
  task automatic cmd(input int u, input logic [1:0] s, input logic [2:0] d, n, m,
                     input logic [1:0] op, sh, input logic a, b, w, l, output int lat);
    src = s; rd = d; rn = n; rm = m; alu_op = op; shift = sh;
    asel = a; bsel = b; wb_en = w; loads = l;
    if (u == 0) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done_u(u)) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic load_imm(input int u, input logic [2:0] r, input logic [15:0] v);
    int lat;
    sximm8 = v;
    cmd(u, 2'd2, r, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, lat);
  endtask

  // R[r] + sximm5(=0) into C with status untouched and no write-back.
  task automatic read_reg(input int u, input logic [2:0] r, output logic [15:0] v);
    int lat;
    sximm5 = '0;
    cmd(u, 2'd0, 3'd0, r, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, lat);
    v = (u == 0) ? dout1 : {8'h00, dout2};
  endtask

  initial begin
    int          lat, ndone;
    logic [15:0] v;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_dout", dout1, 0);
    chk("rst_status", z1, 0);
`ifdef DBG_PORT_EN
    for (int r = 0; r < 8; r++) begin
      dbg_addr1 = r[2:0];
      #1 chk("rst_dbg", dbg_data1, 0);
    end
`endif
    for (int r = 0; r < 8; r++) begin
      read_reg(0, r[2:0], v);
      chk($sformatf("rst_R%0d", r), v, 0);
    end
    chk("rst_status_after_reads", z1, 0);

    // immediate load
    sximm8 = 16'h0042;
    cmd(0, 2'd2, 3'd3, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, lat);
    chk("imm_latency", lat, 1);
    chk("imm_busy_after", busy1, 0);
    chk("imm_dout_unchanged", dout1, 0);
    read_reg(0, 3'd3, v);
    chk("imm_R3", v, 16'h0042);

    // add with lsl: 5 + (3<<1) = 11
    load_imm(0, 3'd1, 16'd5);
    load_imm(0, 3'd2, 16'd3);
    cmd(0, 2'd0, 3'd4, 3'd1, 3'd2, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, lat);
    chk("add_latency", lat, 4);
    chk("add_dout", dout1, 16'd11);
    chk("add_status", z1, 3'b000);
    read_reg(0, 3'd4, v);
    chk("add_R4", v, 16'd11);

    // cmp: 7FFF - FFFF overflows
    load_imm(0, 3'd1, 16'h7FFF);
    load_imm(0, 3'd2, 16'hFFFF);
    cmd(0, 2'd0, 3'd4, 3'd1, 3'd2, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, lat);
    chk("cmp_dout", dout1, 16'h8000);
    chk("cmp_status", z1, 3'b110);
    read_reg(0, 3'd4, v);
    chk("cmp_R4_kept", v, 16'd11);

    // pc source keeps only pc[8:0]
    pc = 16'hFFA5;
    cmd(0, 2'd3, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, lat);
    read_reg(0, 3'd0, v);
    chk("pc_zext_R0", v, 16'h01A5);

    // start during RD_B is ignored: R5 = 7FFF + FFFF, R6 untouched
    src = 2'd0; rd = 3'd5; rn = 3'd1; rm = 3'd2; alu_op = 2'b00; shift = 2'b00;
    asel = 1'b0; bsel = 1'b0; wb_en = 1'b1; loads = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(posedge clk); #1;
    src = 2'd2; rd = 3'd6; sximm8 = 16'h0077; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (done1) ndone++;
      @(posedge clk); #1;
    end
    chk("busy_one_done", ndone, 1);
    read_reg(0, 3'd6, v);
    chk("busy_R6_untouched", v, 0);
    read_reg(0, 3'd5, v);
    chk("busy_R5", v, 16'h7FFE);

    // reset during EXEC aborts write-back of R7
    src = 2'd0; rd = 3'd7; rn = 3'd1; rm = 3'd2; alu_op = 2'b00; shift = 2'b00;
    asel = 1'b0; bsel = 1'b0; wb_en = 1'b1; loads = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_exec", busy1, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy_rst", busy1, 0);
    chk("abort_status_rst", z1, 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_next", busy1, 0);
    chk("abort_done_next", done1, 0);
    read_reg(0, 3'd7, v);
    chk("abort_R7", v, 0);

    // 8-bit / 4-register instance
    load_imm(1, 3'd1, 16'h000F);
    cmd(1, 2'd0, 3'd2, 3'd0, 3'd1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, lat);
    chk("w8_notb_latency", lat, 4);
    chk("w8_notb_dout", dout2, 8'hF0);
    chk("w8_notb_status", z2, 3'b010);
    pc = 16'h01A5;
    cmd(1, 2'd3, 3'd3, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, lat);
    chk("w8_pc_latency", lat, 1);
    read_reg(1, 3'd3, v);
    chk("w8_pc_R3", v, 16'h00A5);
    read_reg(1, 3'd2, v);
    chk("w8_notb_R2", v, 16'h00F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
